// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared constants, types and helpers for the register file
// with integrated busy-bit scoreboard.
//   DEF_XLEN / DEF_NREGS / DEF_AW : default data width, register count, address width
//   MAX_WR                        : widest write-port match vector the helper accepts
//   reg_addr_t / reg_data_t       : address and data types for the default configuration
//   hi_idx()                      : index of the highest set bit of a port-match vector
package reg_file_pkg;

  localparam int DEF_XLEN  = 32;
  localparam int DEF_NREGS = 32;
  localparam int DEF_AW    = $clog2(DEF_NREGS);
  localparam int MAX_WR    = 32;

  typedef logic [DEF_AW-1:0]   reg_addr_t;
  typedef logic [DEF_XLEN-1:0] reg_data_t;

  // Highest-index write port wins whenever several ports hit the same
  // register, both for storage and for read bypass. Callers zero-extend
  // their NWR-bit match vector to MAX_WR bits. With no bit set the result
  // is 0; callers qualify it with the OR of the vector.
  function automatic int hi_idx(input logic [MAX_WR-1:0] vec);
    int idx;
    idx = 32'sd0;
    for (int p = 0; p < MAX_WR; p++) begin
      if (vec[p]) begin
        idx = p;
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: per-register pending-write (busy) tracking.
//   clk, rst          : clock, synchronous active-high reset
//   iss_valid, iss_rd : decode issues an instruction that will write iss_rd
//   flush             : clear every busy bit
//   wen, waddr        : writeback ports; a write clears the target's busy bit
//   busy              : registered busy vector (bit 0 always 0)
//   iss_ready         : iss_rd is free to be issued (from registered busy only)
module rf_scoreboard
  import reg_file_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int NWR   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    iss_valid,
  input  logic [AW-1:0]           iss_rd,
  input  logic                    flush,
  input  logic [NWR-1:0]          wen,
  input  logic [NWR-1:0][AW-1:0]  waddr,
  output logic [NREGS-1:0]        busy,
  output logic                    iss_ready
);

  logic [NREGS-1:0] busy_r;
  logic [NREGS-1:0] busy_nxt_s;
  logic [NREGS-1:0] wclr_s;
  logic             iss_fire_s;

  assign busy = busy_r;

  // Readiness looks only at registered busy: a writeback landing this
  // cycle does not shorten the stall, which keeps this path short.
  always_comb begin
    iss_ready = 1'b0;
    if (iss_rd == {AW{1'b0}}) begin
      iss_ready = 1'b1;
    end else begin
      iss_ready = ~busy_r[iss_rd];
    end
  end

  // An issue is accepted only when the destination is free.
  always_comb begin
    iss_fire_s = iss_valid & iss_ready;
  end

  // Per-register flag: some enabled write port targets this register.
  always_comb begin
    wclr_s = {NREGS{1'b0}};
    for (int r = 0; r < NREGS; r++) begin
      for (int p = 0; p < NWR; p++) begin
        if (wen[p] && (waddr[p] == AW'(r))) begin
          wclr_s[r] = 1'b1;
        end else begin
          wclr_s[r] = wclr_s[r];
        end
      end
    end
  end

  // Next busy state: a new issue beats flush, flush beats a writeback
  // clear, otherwise hold. Register 0 is never busy.
  always_comb begin
    busy_nxt_s = busy_r;
    for (int r = 0; r < NREGS; r++) begin
      if (r == 32'sd0) begin
        busy_nxt_s[r] = 1'b0;
      end else if (iss_fire_s && (iss_rd == AW'(r))) begin
        busy_nxt_s[r] = 1'b1;
      end else if (flush) begin
        busy_nxt_s[r] = 1'b0;
      end else if (wclr_s[r]) begin
        busy_nxt_s[r] = 1'b0;
      end else begin
        busy_nxt_s[r] = busy_r[r];
      end
    end
  end

  // Busy vector register; reset drops any writebacks pending in that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r <= {NREGS{1'b0}};
    end else begin
      busy_r <= busy_nxt_s;
    end
  end

endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port integer register file with busy-bit scoreboard.
//   clk, rst          : clock, synchronous active-high reset (clears data and busy)
//   wen/waddr/wdata   : NWR write ports; highest index wins on conflicts; reg 0 dropped
//   raddr/rdata/rbusy : NRD combinational read ports with optional write bypass
//   iss_valid/iss_rd  : decode issue of an instruction writing iss_rd
//   iss_ready         : iss_rd not busy
//   flush             : clear all busy bits, data untouched
// NWR must not exceed reg_file_pkg::MAX_WR.
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int XLEN   = DEF_XLEN,
  parameter int NREGS  = DEF_NREGS,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter bit BYPASS = 1'b1,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NWR-1:0]           wen,
  input  logic [NWR-1:0][AW-1:0]   waddr,
  input  logic [NWR-1:0][XLEN-1:0] wdata,
  input  logic [NRD-1:0][AW-1:0]   raddr,
  output logic [NRD-1:0][XLEN-1:0] rdata,
  output logic [NRD-1:0]           rbusy,
  input  logic                     iss_valid,
  input  logic [AW-1:0]            iss_rd,
  output logic                     iss_ready,
  input  logic                     flush
);

  localparam int WW = (NWR > 1) ? $clog2(NWR) : 1;

  logic [NREGS-1:0][XLEN-1:0] regs_r;
  logic [NREGS-1:0]           busy_s;
  logic [NWR-1:0]             wmatch_s [NREGS];
  logic [NWR-1:0]             rmatch_s [NRD];

  rf_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .flush     (flush),
    .wen       (wen),
    .waddr     (waddr),
    .busy      (busy_s),
    .iss_ready (iss_ready)
  );

  // Which write ports target each register this cycle.
  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      for (int p = 0; p < NWR; p++) begin
        wmatch_s[r][p] = wen[p] & (waddr[p] == AW'(r));
      end
    end
  end

  // Storage: reg 0 is never written so it stays at its reset value of 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_r <= {(NREGS*XLEN){1'b0}};
    end else begin
      regs_r[0] <= {XLEN{1'b0}};
      for (int r = 1; r < NREGS; r++) begin
        if (|wmatch_s[r]) begin
          regs_r[r] <= wdata[WW'(hi_idx(MAX_WR'(wmatch_s[r])))];
        end else begin
          regs_r[r] <= regs_r[r];
        end
      end
    end
  end

  // Which enabled, non-zero write ports hit each read address.
  always_comb begin
    for (int q = 0; q < NRD; q++) begin
      for (int p = 0; p < NWR; p++) begin
        rmatch_s[q][p] = wen[p] & (waddr[p] != {AW{1'b0}}) & (waddr[p] == raddr[q]);
      end
    end
  end

  // Read muxes. A bypassed read reports not-busy because the pending
  // value is the one being delivered right now.
  always_comb begin
    rdata = {(NRD*XLEN){1'b0}};
    rbusy = {NRD{1'b0}};
    for (int q = 0; q < NRD; q++) begin
      if (raddr[q] == {AW{1'b0}}) begin
        rdata[q] = {XLEN{1'b0}};
        rbusy[q] = 1'b0;
      end else if (BYPASS && (|rmatch_s[q])) begin
        rdata[q] = wdata[WW'(hi_idx(MAX_WR'(rmatch_s[q])))];
        rbusy[q] = 1'b0;
      end else begin
        rdata[q] = regs_r[raddr[q]];
        rbusy[q] = busy_s[raddr[q]];
      end
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed plus random stimulus on two instances of
// reg_file_sb (bypass on / bypass off) sharing all inputs, checked against
// a behavioural array model of registers and busy flags.
module tb_reg_file_sb;
  import reg_file_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           wen;
  logic [1:0][4:0]      waddr;
  logic [1:0][31:0]     wdata;
  logic [1:0][4:0]      raddr;
  logic                 iss_valid;
  logic [4:0]           iss_rd;
  logic                 flush;
  logic [1:0][31:0]     rdata_b, rdata_n;
  logic [1:0]           rbusy_b, rbusy_n;
  logic                 iss_ready_b, iss_ready_n;

  int errors = 0;
  int checks = 0;

  reg_data_t mem_m  [32];
  logic      busy_m [32];

  always #5 clk = ~clk;

  reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1'b1)) u_byp (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready_b), .flush(flush)
  );

  reg_file_sb #(.XLEN(32), .NREGS(32), .NRD(2), .NWR(2), .BYPASS(1'b0)) u_nobyp (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready_n), .flush(flush)
  );

  task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] got=%h expected=%h", tag, idx, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_rdata(input int q, input bit byp);
    logic [31:0] v;
    bit          hit;
    reg_addr_t   a;
    a   = raddr[q];
    v   = mem_m[a];
    hit = 1'b0;
    if (byp) begin
      for (int p = 1; p >= 0; p--) begin
        if (!hit && wen[p] && waddr[p] == a) begin
          v   = wdata[p];
          hit = 1'b1;
        end
      end
    end
    if (a == 5'd0) v = 32'h0;
    return v;
  endfunction

  function automatic logic exp_rbusy(input int q, input bit byp);
    logic      b;
    reg_addr_t a;
    a = raddr[q];
    b = busy_m[a];
    if (byp) begin
      for (int p = 0; p < 2; p++) begin
        if (wen[p] && waddr[p] == a) b = 1'b0;
      end
    end
    if (a == 5'd0) b = 1'b0;
    return b;
  endfunction

  function automatic logic exp_ready();
    return (iss_rd == 5'd0) || !busy_m[iss_rd];
  endfunction

  task automatic model_update();
    bit ok;
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        mem_m[i]  = 32'h0;
        busy_m[i] = 1'b0;
      end
    end else begin
      ok = iss_valid && exp_ready();
      for (int p = 0; p < 2; p++) begin
        if (wen[p] && waddr[p] != 5'd0) begin
          mem_m[waddr[p]]  = wdata[p];
          busy_m[waddr[p]] = 1'b0;
        end
      end
      if (flush) begin
        for (int i = 0; i < 32; i++) busy_m[i] = 1'b0;
      end
      if (ok && iss_rd != 5'd0) busy_m[iss_rd] = 1'b1;
    end
  endtask

  task automatic check_all();
    for (int q = 0; q < 2; q++) begin
      check("rdata_byp",   q, rdata_b[q],          exp_rdata(q, 1'b1));
      check("rbusy_byp",   q, {31'd0, rbusy_b[q]}, {31'd0, exp_rbusy(q, 1'b1)});
      check("rdata_nobyp", q, rdata_n[q],          exp_rdata(q, 1'b0));
      check("rbusy_nobyp", q, {31'd0, rbusy_n[q]}, {31'd0, exp_rbusy(q, 1'b0)});
    end
    check("iss_ready_byp",   0, {31'd0, iss_ready_b}, {31'd0, exp_ready()});
    check("iss_ready_nobyp", 0, {31'd0, iss_ready_n}, {31'd0, exp_ready()});
  endtask

  task automatic settle();
    @(negedge clk);
    check_all();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle();
    rst = 1'b0; wen = '0; waddr = '0; wdata = '0;
    iss_valid = 1'b0; iss_rd = 5'd0; flush = 1'b0;
  endtask

  initial begin
    raddr = '0;
    idle();
    rst = 1'b1;
    @(posedge clk);
    model_update();
    #1;

    // reset state
    idle(); raddr[0] = 5'd5; raddr[1] = 5'd31; iss_rd = 5'd5;
    settle();
    check("rst_rdata", 0, rdata_b[0], 32'h0);
    check("rst_rdata", 1, rdata_b[1], 32'h0);
    check("rst_rbusy", 0, {30'd0, rbusy_b}, 32'h0);
    check("rst_ready", 0, {31'd0, iss_ready_b}, 32'h1);
    advance();

    // write-port conflict on reg 7
    wen = 2'b11; waddr[0] = 5'd7; waddr[1] = 5'd7;
    wdata[1] = 32'hAAAA_0000; wdata[0] = 32'h1111_1111; raddr[0] = 5'd7;
    settle();
    check("conflict_bypass", 0, rdata_b[0], 32'hAAAA_0000);
    check("conflict_nobyp",  0, rdata_n[0], 32'h0);
    advance();
    idle();
    settle();
    check("conflict_stored", 0, rdata_b[0], 32'hAAAA_0000);
    check("conflict_stored", 1, rdata_n[0], 32'hAAAA_0000);
    advance();

    // register 0
    wen = 2'b01; waddr[0] = 5'd0; wdata[0] = 32'hFFFF_FFFF; raddr[0] = 5'd0;
    iss_valid = 1'b1; iss_rd = 5'd0;
    settle();
    check("r0_rdata", 0, rdata_b[0], 32'h0);
    check("r0_ready", 0, {31'd0, iss_ready_b}, 32'h1);
    advance();
    idle(); raddr[0] = 5'd0;
    settle();
    check("r0_after", 0, rdata_b[0], 32'h0);
    check("r0_rbusy", 0, {31'd0, rbusy_b[0]}, 32'h0);
    advance();

    // scoreboard lifecycle on reg 3
    iss_valid = 1'b1; iss_rd = 5'd3;
    settle(); advance();
    idle(); iss_rd = 5'd3; raddr[0] = 5'd3;
    settle();
    check("life_ready_busy", 0, {31'd0, iss_ready_b}, 32'h0);
    check("life_rbusy",      0, {31'd0, rbusy_b[0]}, 32'h1);
    advance();
    wen = 2'b01; waddr[0] = 5'd3; wdata[0] = 32'h0000_1234;
    settle();
    check("life_wb_rbusy", 0, {31'd0, rbusy_b[0]}, 32'h0);
    check("life_wb_rdata", 0, rdata_b[0], 32'h0000_1234);
    check("life_wb_nobyp", 0, {31'd0, rbusy_n[0]}, 32'h1);
    advance();
    idle(); iss_rd = 5'd3; raddr[0] = 5'd3;
    settle();
    check("life_ready_free", 0, {31'd0, iss_ready_b}, 32'h1);
    advance();

    // simultaneous issue and write on reg 9
    iss_valid = 1'b1; iss_rd = 5'd9; wen = 2'b10; waddr[1] = 5'd9; wdata[1] = 32'hCAFE_0009;
    settle(); advance();
    idle(); iss_rd = 5'd9; raddr[1] = 5'd9;
    settle();
    check("iw_rbusy", 1, {31'd0, rbusy_b[1]}, 32'h1);
    check("iw_rdata", 1, rdata_b[1], 32'hCAFE_0009);
    advance();

    // flush with concurrent issue
    idle(); wen = 2'b11; waddr[0] = 5'd4; wdata[0] = 32'h44; waddr[1] = 5'd5; wdata[1] = 32'h55;
    settle(); advance();
    idle(); wen = 2'b01; waddr[0] = 5'd6; wdata[0] = 32'h66; iss_valid = 1'b1; iss_rd = 5'd4;
    settle(); advance();
    idle(); iss_valid = 1'b1; iss_rd = 5'd5;
    settle(); advance();
    idle(); iss_valid = 1'b1; iss_rd = 5'd6;
    settle(); advance();
    idle(); wen = 2'b01; waddr[0] = 5'd5; wdata[0] = 32'h55;
    settle(); advance();
    idle(); flush = 1'b1; iss_valid = 1'b1; iss_rd = 5'd5;
    settle();
    check("flush_iss_ready", 0, {31'd0, iss_ready_b}, 32'h1);
    advance();
    idle(); raddr[0] = 5'd4; raddr[1] = 5'd5; iss_rd = 5'd6;
    settle();
    check("flush_busy4", 0, {31'd0, rbusy_b[0]}, 32'h0);
    check("flush_busy5", 1, {31'd0, rbusy_b[1]}, 32'h1);
    check("flush_busy6", 0, {31'd0, iss_ready_b}, 32'h1);
    check("flush_data4", 0, rdata_b[0], 32'h44);
    check("flush_data5", 1, rdata_b[1], 32'h55);
    advance();

    // reset wins over a same-cycle write
    idle(); rst = 1'b1; wen = 2'b01; waddr[0] = 5'd4; wdata[0] = 32'hDEAD_BEEF;
    settle(); advance();
    idle(); raddr[0] = 5'd4; raddr[1] = 5'd5;
    settle();
    check("rst_wr_data", 0, rdata_b[0], 32'h0);
    check("rst_busy5",   1, {31'd0, rbusy_b[1]}, 32'h0);
    advance();

    // random traffic on a small register window to force collisions
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 63) == 0);
      wen       = 2'($urandom_range(0, 3));
      waddr[0]  = 5'($urandom_range(0, 7));
      waddr[1]  = 5'($urandom_range(0, 7));
      wdata[0]  = $urandom;
      wdata[1]  = $urandom;
      raddr[0]  = 5'($urandom_range(0, 7));
      raddr[1]  = 5'($urandom_range(0, 7));
      iss_valid = 1'($urandom_range(0, 1));
      iss_rd    = 5'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 15) == 0);
      settle();
      advance();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised multi-port integer register file with an integrated busy-bit scoreboard.
- Serves the decode/writeback stages of the pipelined core.
- Supports NRD read ports and NWR write ports, with optional write-to-read bypass.
- Provides per-register pending tracking so decode can stall on RAW/WAW hazards when writebacks are long-latency or out of order.
- Register 0 is hardwired to zero.

Parameters:
XLEN, 32, data width in bits
NREGS, 32, number of architectural registers (power of two, >=2); AW = $clog2(NREGS)
NRD, 2, number of read ports (>=1)
NWR, 2, number of write ports (>=1)
BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads see stored value only

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
wen  in  NWR  per-port write enable
waddr  in  NWR x AW  per-port write address
wdata  in  NWR x XLEN  per-port write data
raddr  in  NRD x AW  per-port read address
rdata  out  NRD x XLEN  per-port read data (combinational)
rbusy  out  NRD  read register has a pending write (combinational)
iss_valid  in  1  decode issues an instruction that will write iss_rd
iss_rd  in  AW  destination register of issuing instruction
iss_ready  out  1  iss_rd not busy (combinational)
flush  in  1  clear all busy bits (pipeline flush); data untouched

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high. At a clk edge with rst=1, all registers become 0 and all busy bits become 0. Writes, issue and flush are ignored in that cycle.
- Output values after reset: rdata = 0 on all ports, rbusy = 0, iss_ready = 1, until new state is written.
- Writes:
  - At a clk edge, each port p with wen[p]=1 and waddr[p]!=0 stores wdata[p].
  - Several ports targeting the same address: the highest-index port wins.
  - Writes to address 0 are dropped.
- Reads (combinational, zero latency):
  - raddr=0 gives rdata=0 and rbusy=0.
  - Otherwise, with BYPASS=1, if any enabled write port (non-zero address) matches raddr: rdata = wdata of the highest-index matching port, and rbusy = 0.
  - Otherwise rdata = stored value and rbusy = busy[raddr].
  - With BYPASS=0: rdata = stored value and rbusy = busy[raddr] regardless of same-cycle writes. The new value is visible the next cycle.
- Scoreboard, per register r != 0, with next-state priority highest first:
  1. rst gives 0.
  2. iss_valid && iss_ready && iss_rd==r gives 1. A new issue wins over a same-cycle write or flush of r.
  3. flush gives 0.
  4. any enabled write port with waddr==r gives 0.
  5. otherwise hold.
- busy[0] is constantly 0. Issue to rd=0 sets nothing.
- iss_ready = (iss_rd==0) || !busy[iss_rd]. It is computed from registered busy, with no bypass from same-cycle writes, to keep the timing path short.
- iss_valid with iss_ready=0 is ignored and does not change state. The issuer holds and retries.
- Write to a non-busy register is legal: data stored, busy stays 0.
- Reset mid-operation: pending writebacks asserted in the reset cycle are lost. This is intended; the pipeline is flushed on reset.

Decomposition:
- Package reg_file_pkg:
  - XLEN default constant.
  - reg_addr_t typedef, logic [AW-1:0] for the default NREGS.
  - reg_data_t typedef, logic [XLEN-1:0].
  - Function for the highest-index write-port match, shared by the write and bypass logic.
- Sub-module rf_scoreboard holds the busy vector, issue/flush/clear priority and iss_ready. It is parametrised by NREGS and NWR.
- The top level keeps the storage array, write arbitration and read/bypass muxes.

Test Plan:
- Reset then read: after rst=1 for one cycle, raddr={5,31} gives rdata={0,0}, rbusy={0,0} and iss_ready=1.
- Write-port conflict: wen=2'b11, waddr={7,7}, wdata={0xAAAA_0000 (port1), 0x1111_1111 (port0)}. With BYPASS=1, raddr0=7 in the same cycle gives 0xAAAA_0000. Next cycle the stored value is also 0xAAAA_0000. With BYPASS=0, the same-cycle read gives the old value 0.
- Register 0: wen[0]=1, waddr=0, wdata=0xFFFF_FFFF, then read raddr=0 gives 0. iss_valid with iss_rd=0 gives iss_ready=1 and rbusy stays 0.
- Scoreboard lifecycle: issue rd=3, then next cycle iss_rd=3 gives iss_ready=0 and raddr=3 gives rbusy=1. A write to 3 with 0x1234 gives a same-cycle rbusy=0 and rdata=0x1234 (BYPASS=1), and iss_ready=1 the cycle after.
- Simultaneous issue and write on rd=9 (busy=0 before): afterwards busy[9]=1. The stored value equals the written data.
- Flush: set busy on regs 4, 5 and 6, then flush=1 with iss_valid on rd=5. Afterwards busy={4:0, 5:1, 6:0} and data is unchanged. rst asserted in a cycle with wen=1 to reg 4 gives reg 4 = 0.
